// File: rtl/if_prefetch_queue_if.sv
// Instruction-fetch side of the sram-like bus: read-only requests,
// in-order data return.
interface if_prefetch_queue_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, addr, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, addr, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/if_prefetch_queue.sv
// Prefetching IF stage: several reads in flight, returned words buffered in a
// small FIFO toward ID, prioritised redirects with stale-response discard.
module if_prefetch_queue #(
   parameter int          QDEPTH          = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          NUM_REDIRECT    = 6,
   parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REDIRECT-1:0]    redirect_valid,
   input  logic [32*NUM_REDIRECT-1:0] redirect_target,
   if_prefetch_queue_if.master        bus,
   input  logic [5:0]                 mmu_ecode_i,
   input  logic [8:0]                 mmu_esubcode_i,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                PC_out,
   output logic [31:0]                inst_out,
   output logic                       has_exception_out,
   output logic [5:0]                 ecode_out,
   output logic [8:0]                 esubcode_out,
   output logic [31:0]                exception_maddr_out,
   output logic [$clog2(QDEPTH):0]    queue_count
);
   localparam int QW = $clog2(QDEPTH);
   localparam int CW = QW + 1;
   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [5:0] ECODE_ADEF = 6'h08;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        exc;
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic [31:0] maddr;
   } entry_t;

   localparam entry_t ENTRY_NONE = '{pc: 32'h0, inst: 32'h0, exc: 1'b0,
                                     ecode: 6'h00, esub: 9'h000, maddr: 32'h0};

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          halted_q, halted_d;
   logic [OW-1:0] outst_q, outst_d;
   logic [OW-1:0] disc_q, disc_d;
   logic [QW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] pwr_q, pwr_d, prd_q, prd_d;
   logic [31:0]   pend_q [MAX_OUTSTANDING];
   entry_t        fifo_q [QDEPTH];

   logic          redir_any_s;
   logic [31:0]   redir_tgt_s;
   logic          adef_s, fetch_exc_s, space_s, req_s, accept_s;
   logic          data_push_s, exc_push_s, push_s, pop_s;
   entry_t        push_entry_s, head_s;

   function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   // Lowest-numbered valid channel wins: scan from the top so it is written last.
   always_comb begin
      redir_tgt_s = 32'h0;
      for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
         redir_tgt_s = redirect_valid[i] ? redirect_target[32*i +: 32] : redir_tgt_s;
      end
   end

   assign redir_any_s = |redirect_valid;
   assign adef_s      = fetch_pc_q[1:0] != 2'b00;
   assign fetch_exc_s = adef_s | (mmu_ecode_i != 6'h00);
   // In-flight requests reserve FIFO slots so a response can never overflow it.
   assign space_s     = (32'(count_q) + 32'(outst_q)) < 32'(QDEPTH);
   assign req_s       = ~halted_q & ~fetch_exc_s & ~redir_any_s & space_s
                        & (32'(outst_q) < 32'(MAX_OUTSTANDING));
   assign accept_s    = req_s & bus.addr_ok;
   assign data_push_s = bus.data_ok & ~redir_any_s & (disc_q == {OW{1'b0}});
   assign exc_push_s  = fetch_exc_s & ~halted_q & (outst_q == {OW{1'b0}}) & space_s
                        & ~redir_any_s & ~bus.data_ok;
   assign push_s      = data_push_s | exc_push_s;
   assign pop_s       = (count_q != {CW{1'b0}}) & out_ready & ~redir_any_s;

   always_comb begin
      push_entry_s = ENTRY_NONE;
      if (exc_push_s) begin
         push_entry_s.pc  = fetch_pc_q;
         push_entry_s.exc = 1'b1;
         if (adef_s) begin
            push_entry_s.ecode = ECODE_ADEF;
            push_entry_s.esub  = 9'h000;
            push_entry_s.maddr = fetch_pc_q;
         end else begin
            push_entry_s.ecode = mmu_ecode_i;
            push_entry_s.esub  = mmu_esubcode_i;
            push_entry_s.maddr = {fetch_pc_q[31:2], 2'b00};
         end
      end else begin
         push_entry_s.pc   = pend_q[prd_q];
         push_entry_s.inst = bus.rdata;
      end
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      halted_d   = halted_q;
      outst_d    = outst_q + OW'(accept_s) - OW'(bus.data_ok);
      disc_d     = disc_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      pwr_d      = accept_s ? pend_inc(pwr_q) : pwr_q;
      prd_d      = bus.data_ok ? pend_inc(prd_q) : prd_q;
      if (redir_any_s) begin
         // Every response still in flight is stale, including ones already marked.
         fetch_pc_d = redir_tgt_s;
         halted_d   = 1'b0;
         disc_d     = outst_q - OW'(bus.data_ok);
         wptr_d     = {QW{1'b0}};
         rptr_d     = {QW{1'b0}};
         count_d    = {CW{1'b0}};
      end else begin
         if (accept_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end else begin
            fetch_pc_d = fetch_pc_q;
         end
         if (exc_push_s) begin
            halted_d = 1'b1;
         end else begin
            halted_d = halted_q;
         end
         if (bus.data_ok && (disc_q != {OW{1'b0}})) begin
            disc_d = disc_q - OW'(1);
         end else begin
            disc_d = disc_q;
         end
         wptr_d  = wptr_q + QW'(push_s);
         rptr_d  = rptr_q + QW'(pop_s);
         count_d = count_q + CW'(push_s) - CW'(pop_s);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         halted_q   <= 1'b0;
         outst_q    <= {OW{1'b0}};
         disc_q     <= {OW{1'b0}};
         wptr_q     <= {QW{1'b0}};
         rptr_q     <= {QW{1'b0}};
         count_q    <= {CW{1'b0}};
         pwr_q      <= {PW{1'b0}};
         prd_q      <= {PW{1'b0}};
      end else begin
         fetch_pc_q <= fetch_pc_d;
         halted_q   <= halted_d;
         outst_q    <= outst_d;
         disc_q     <= disc_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         pwr_q      <= pwr_d;
         prd_q      <= prd_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) pend_q[i] <= 32'h0;
         for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= ENTRY_NONE;
      end else begin
         if (accept_s) pend_q[pwr_q] <= fetch_pc_q;
         if (push_s) fifo_q[wptr_q] <= push_entry_s;
      end
   end

   assign head_s = fifo_q[rptr_q];

   always_comb begin
      if (count_q != {CW{1'b0}}) begin
         PC_out              = head_s.pc;
         inst_out            = head_s.inst;
         has_exception_out   = head_s.exc;
         ecode_out           = head_s.ecode;
         esubcode_out        = head_s.esub;
         exception_maddr_out = head_s.maddr;
      end else begin
         PC_out              = 32'h0;
         inst_out            = 32'h0;
         has_exception_out   = 1'b0;
         ecode_out           = 6'h00;
         esubcode_out        = 9'h000;
         exception_maddr_out = 32'h0;
      end
   end

   assign out_valid   = count_q != {CW{1'b0}};
   assign queue_count = count_q;

   assign bus.req   = req_s;
   assign bus.wr    = 1'b0;
   assign bus.size  = 2'b10;
   assign bus.addr  = {fetch_pc_q[31:2], 2'b00};
   assign bus.wstrb = 4'h0;
   assign bus.wdata = 32'h0;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Randomised bench for if_prefetch_queue: an in-order memory slave plus a
// queue-based reference of the fetch stream, checked every cycle.
module tb_if_prefetch_queue;
   localparam int          QDEPTH   = 4;
   localparam int          MAXO     = 2;
   localparam int          NR       = 6;
   localparam logic [31:0] RESET_PC = 32'h1c000000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        exc;
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic [31:0] maddr;
   } ent_t;

   typedef struct {
      logic [31:0] pc;
      bit          stale;
   } fl_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [NR-1:0]  redirect_valid;
   logic [32*NR-1:0] redirect_target;
   logic [5:0]     mmu_ecode;
   logic [8:0]     mmu_esub;
   logic           out_valid, out_ready;
   logic [31:0]    PC_out, inst_out, exception_maddr_out;
   logic           has_exception_out;
   logic [5:0]     ecode_out;
   logic [8:0]     esubcode_out;
   logic [2:0]     queue_count;

   if_prefetch_queue_if bus ();

   if_prefetch_queue #(.QDEPTH(QDEPTH), .MAX_OUTSTANDING(MAXO), .NUM_REDIRECT(NR),
                       .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .bus(bus),
      .mmu_ecode_i(mmu_ecode), .mmu_esubcode_i(mmu_esub),
      .out_valid(out_valid), .out_ready(out_ready), .PC_out(PC_out),
      .inst_out(inst_out), .has_exception_out(has_exception_out),
      .ecode_out(ecode_out), .esubcode_out(esubcode_out),
      .exception_maddr_out(exception_maddr_out), .queue_count(queue_count)
   );

   always #5 clk = ~clk;

   bit          mmu_en;
   logic [23:0] bad_page;

   function automatic logic [5:0] mmu_code(input logic [31:0] a);
      return (mmu_en && a[31:8] == bad_page) ? 6'h03 : 6'h00;
   endfunction

   function automatic logic [8:0] mmu_sub(input logic [31:0] a);
      return (mmu_en && a[31:8] == bad_page) ? 9'h01a : 9'h000;
   endfunction

   function automatic logic [31:0] mkinst(input logic [31:0] pc);
      return {pc[15:0], pc[31:16]} ^ 32'h5a5ac3c3;
   endfunction

   assign mmu_ecode = mmu_code(bus.addr);
   assign mmu_esub  = mmu_sub(bus.addr);

   ent_t        exp_q[$];
   fl_t         infl[$];
   logic [31:0] m_pc;
   bit          m_halt;
   int          n_chk = 0;
   int          n_err = 0;

   logic [NR-1:0] rv;
   logic [31:0]   tg [NR];
   bit            aok, dok_want, ordy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      infl.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
   endtask

   // One clock: drive at the falling edge, check, advance the reference model.
   task automatic step();
      bit          redir, space, req_exp, exc_m, pop_m, xpush, acc, misal;
      logic [31:0] tgt, al;
      fl_t         hd;
      ent_t        e;
      redirect_valid = rv;
      for (int i = 0; i < NR; i++) redirect_target[32*i +: 32] = tg[i];
      bus.addr_ok  = aok;
      bus.data_ok  = dok_want && (infl.size() > 0);
      bus.rdata    = bus.data_ok ? mkinst(infl[0].pc) : 32'h0;
      out_ready    = ordy;
      #1;
      redir = (rv != '0);
      tgt   = 32'h0;
      for (int i = NR - 1; i >= 0; i--) if (rv[i]) tgt = tg[i];
      al      = m_pc & ~32'h3;
      misal   = (m_pc[1:0] != 2'b00);
      exc_m   = misal || (mmu_code(al) != 6'h00);
      space   = (exp_q.size() + infl.size()) < QDEPTH;
      req_exp = !m_halt && !exc_m && !redir && (infl.size() < MAXO) && space;
      chk("req", {31'h0, bus.req}, {31'h0, req_exp});
      if (req_exp) chk("addr", bus.addr, m_pc);
      chk("out_valid", {31'h0, out_valid}, (exp_q.size() != 0) ? 32'h1 : 32'h0);
      chk("queue_count", {29'h0, queue_count}, exp_q.size());
      if (exp_q.size() != 0) begin
         chk("PC_out", PC_out, exp_q[0].pc);
         chk("inst_out", inst_out, exp_q[0].inst);
         chk("has_exc", {31'h0, has_exception_out}, {31'h0, exp_q[0].exc});
         chk("ecode", {26'h0, ecode_out}, {26'h0, exp_q[0].ecode});
         chk("esubcode", {23'h0, esubcode_out}, {23'h0, exp_q[0].esub});
         chk("maddr", exception_maddr_out, exp_q[0].maddr);
      end
      acc   = req_exp && aok;
      pop_m = (exp_q.size() != 0) && ordy && !redir;
      xpush = exc_m && !m_halt && (infl.size() == 0) && space && !redir;
      if (redir) foreach (infl[i]) infl[i].stale = 1'b1;
      if (pop_m) void'(exp_q.pop_front());
      if (bus.data_ok) begin
         hd = infl.pop_front();
         if (!hd.stale) exp_q.push_back('{hd.pc, mkinst(hd.pc), 1'b0, 6'h00, 9'h000, 32'h0});
      end
      if (xpush) begin
         e.pc    = m_pc;
         e.inst  = 32'h0;
         e.exc   = 1'b1;
         e.ecode = misal ? 6'h08 : mmu_code(al);
         e.esub  = misal ? 9'h000 : mmu_sub(al);
         e.maddr = misal ? m_pc : al;
         exp_q.push_back(e);
         m_halt = 1'b1;
      end
      if (acc) begin
         infl.push_back('{m_pc, 1'b0});
         m_pc = m_pc + 32'd4;
      end
      if (redir) begin
         exp_q.delete();
         m_pc   = tgt;
         m_halt = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rv = '0; aok = 1'b0; dok_want = 1'b0; ordy = 1'b0;
      redirect_valid = '0;
      bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = 32'h0;
      out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_count", {29'h0, queue_count}, 32'h0);
      chk("rst_PC_out", PC_out, 32'h0);
      chk("rst_inst", inst_out, 32'h0);
      chk("rst_maddr", exception_maddr_out, 32'h0);
      chk("rst_addr", bus.addr, RESET_PC);
      rst = 1'b0;
   endtask

   initial begin
      mmu_en   = 1'b0;
      bad_page = 24'h1c0002;
      for (int i = 0; i < NR; i++) tg[i] = 32'h0;
      do_reset();

      // Streaming with everything ready.
      aok = 1'b1; dok_want = 1'b1; ordy = 1'b1;
      repeat (12) step();

      // Consumer stalled: the queue fills, then fetch resumes.
      do_reset();
      aok = 1'b1; dok_want = 1'b1; ordy = 1'b0;
      repeat (8) step();
      chk("full_count", {29'h0, queue_count}, 32'd4);
      chk("full_req", {31'h0, bus.req}, 32'h0);
      ordy = 1'b1;
      step();
      chk("resume_addr", bus.addr, 32'h1c000010);
      repeat (6) step();

      // Two channels at once with two requests in flight.
      do_reset();
      aok = 1'b1; dok_want = 1'b0; ordy = 1'b0;
      repeat (2) step();
      tg[5] = 32'h1c000100; tg[0] = 32'h1c008000;
      rv = 6'b100001;
      step();
      rv = '0; dok_want = 1'b1;
      repeat (6) step();
      chk("prio_pc", PC_out, 32'h1c008000);

      // Misaligned target: a single address-error entry, then halted.
      do_reset();
      aok = 1'b1; dok_want = 1'b1; ordy = 1'b0;
      tg[0] = 32'h1c000102; rv = 6'b000001;
      step();
      rv = '0;
      repeat (4) step();
      chk("adef_ecode", {26'h0, ecode_out}, 32'h8);
      chk("adef_maddr", exception_maddr_out, 32'h1c000102);
      chk("adef_pc", PC_out, 32'h1c000102);
      ordy = 1'b1;
      repeat (4) step();
      chk("halted_count", {29'h0, queue_count}, 32'h0);

      // MMU fault at the target page.
      mmu_en = 1'b1;
      ordy = 1'b0; tg[2] = 32'h1c000200; rv = 6'b000100;
      step();
      rv = '0;
      repeat (4) step();
      chk("mmu_exc", {31'h0, has_exception_out}, 32'h1);
      chk("mmu_ecode", {26'h0, ecode_out}, 32'h3);
      chk("mmu_maddr", exception_maddr_out, 32'h1c000200);
      chk("mmu_inst", inst_out, 32'h0);

      // Random traffic, redirects and faults.
      bad_page = 24'h1c0003;
      for (int n = 0; n < 3000; n++) begin
         aok      = ($urandom_range(0, 3) != 0);
         dok_want = ($urandom_range(0, 2) != 0);
         ordy     = ($urandom_range(0, 3) != 0);
         rv       = '0;
         if ($urandom_range(0, 24) == 0) begin
            rv = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
               case ($urandom_range(0, 7))
                  0:       tg[i] = 32'hfffffff8;
                  1:       tg[i] = 32'h1c000000 + 32'($urandom_range(0, 1023)) * 32'd4
                                   + 32'($urandom_range(1, 3));
                  default: tg[i] = 32'h1c000000 + 32'($urandom_range(0, 1023)) * 32'd4;
               endcase
            end
         end
         step();
      end

      // Asynchronous reset in the middle of traffic.
      mmu_en = 1'b0;
      tg[0] = 32'h1c000400; rv = 6'b000001; aok = 1'b1; dok_want = 1'b1; ordy = 1'b0;
      step();
      rv = '0;
      repeat (5) step();
      #2 rst = 1'b1;
      #1;
      chk("async_valid", {31'h0, out_valid}, 32'h0);
      chk("async_count", {29'h0, queue_count}, 32'h0);
      bus.data_ok = 1'b0; bus.addr_ok = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_addr", bus.addr, RESET_PC);
      chk("post_rst_req", {31'h0, bus.req}, 32'h1);
      aok = 1'b1; dok_want = 1'b1; ordy = 1'b1;
      repeat (6) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end
endmodule
